hazard_fwd_unit: RTL and testbench

//  Parametrised hazard/forwarding controller for the MIPS150 pipeline; successor to per-instruction ALU-select decode.

---
 rtl/hazard_fwd_unit.sv | 163 ++++++++++++++++
 tb/tb_hazard_fwd_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_unit.sv
// Load-use hazard / operand-forwarding controller; optional HAZARD_STATS_EN adds stall_cnt/flush_cnt ports.
// Latency: fwd_sel/stall/flush/issue combinational from ID inputs + scoreboard; scoreboard updates next edge.
// Backpressure: mem_busy freezes the scoreboard and holds PC/IF-ID; load-use inserts bubbles until forwardable.
module hazard_fwd_unit #(
    parameter int NSTAGES  = 2,
    parameter int REGW     = 5,
    parameter int LOAD_LAT = 1,
    parameter int SELW     = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            id_valid,
    input  logic [REGW-1:0] id_rs,
    input  logic [REGW-1:0] id_rt,
    input  logic            id_use_rs,
    input  logic            id_use_rt,
    input  logic            id_wr_en,
    input  logic [REGW-1:0] id_wr_reg,
    input  logic            id_is_load,
    input  logic            br_taken,
    input  logic            mem_busy,
    output logic [SELW-1:0] fwd_sel_a,
    output logic [SELW-1:0] fwd_sel_b,
    output logic            stall,
    output logic            flush,
    output logic            issue
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]     stall_cnt,
    output logic [15:0]     flush_cnt
`endif
);

    typedef enum logic [1:0] {RUN, LDSTALL, FREEZE} state_t;

    state_t state_q, state_d;

    // Scoreboard: entry 0 is the instruction now in EX, NSTAGES-1 the oldest.
    logic [NSTAGES-1:0] sb_v;
    logic [NSTAGES-1:0] sb_ld;
    logic [REGW-1:0]    sb_reg [NSTAGES];

    logic [SELW-1:0] sel_a, sel_b;
    logic            haz_a, haz_b, hazard;
    logic            stall_i, flush_i, issue_i, shift_en;

    // Walk oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        haz_a = 1'b0;
        haz_b = 1'b0;
        for (int k = NSTAGES - 1; k >= 0; k--) begin
            if (id_use_rs && sb_v[k] && (sb_reg[k] == id_rs) && (id_rs != '0)) begin
                sel_a = SELW'(k + 1);
                haz_a = sb_ld[k] && (k < LOAD_LAT);
            end
            if (id_use_rt && sb_v[k] && (sb_reg[k] == id_rt) && (id_rt != '0)) begin
                sel_b = SELW'(k + 1);
                haz_b = sb_ld[k] && (k < LOAD_LAT);
            end
        end
    end

    assign hazard = id_valid && (haz_a || haz_b);

    // state_d is the mode of the current cycle; state_q remembers the previous one.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (mem_busy)
                    state_d = FREEZE;
                else if (hazard && !br_taken)
                    state_d = LDSTALL;
                else
                    state_d = RUN;
            end
            LDSTALL: begin
                if (mem_busy)
                    state_d = FREEZE;
                else if (br_taken || !hazard)
                    state_d = RUN;
                else
                    state_d = LDSTALL;
            end
            FREEZE: begin
                if (mem_busy)
                    state_d = FREEZE;
                else if (hazard && !br_taken)
                    state_d = LDSTALL;
                else
                    state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        stall_i  = 1'b0;
        flush_i  = 1'b0;
        issue_i  = 1'b0;
        shift_en = 1'b1;
        unique case (state_d)
            FREEZE: begin
                stall_i  = 1'b1;
                shift_en = 1'b0;
            end
            LDSTALL: stall_i = 1'b1;
            default: begin
                flush_i = br_taken;
                issue_i = id_valid && !br_taken;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_q <= RUN;
        else
            state_q <= state_d;
    end

    // Non-issuing cycles (stall, flush) shift a bubble into entry 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sb_v  <= '0;
            sb_ld <= '0;
            for (int k = 0; k < NSTAGES; k++)
                sb_reg[k] <= '0;
        end else if (shift_en) begin
            for (int k = 1; k < NSTAGES; k++) begin
                sb_v[k]   <= sb_v[k-1];
                sb_ld[k]  <= sb_ld[k-1];
                sb_reg[k] <= sb_reg[k-1];
            end
            sb_v[0]   <= issue_i && id_wr_en;
            sb_ld[0]  <= issue_i && id_is_load;
            sb_reg[0] <= issue_i ? id_wr_reg : '0;
        end
    end

    assign fwd_sel_a = reset_n ? sel_a : '0;
    assign fwd_sel_b = reset_n ? sel_b : '0;
    assign stall     = reset_n && stall_i;
    assign flush     = reset_n && flush_i;
    assign issue     = reset_n && issue_i;

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if ((state_d == LDSTALL) && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
            if (flush_i && (flush_cnt != 16'hFFFF))
                flush_cnt <= flush_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Scoreboard bench for hazard_fwd_unit: queue-based reference pipeline, directed spec cases then random traffic.
module tb_hazard_fwd_unit;
    localparam int NS = 2;
    localparam int RW = 5;
    localparam int LL = 1;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          id_valid = 1'b0;
    logic [RW-1:0] id_rs = '0;
    logic [RW-1:0] id_rt = '0;
    logic          id_use_rs = 1'b0;
    logic          id_use_rt = 1'b0;
    logic          id_wr_en = 1'b0;
    logic [RW-1:0] id_wr_reg = '0;
    logic          id_is_load = 1'b0;
    logic          br_taken = 1'b0;
    logic          mem_busy = 1'b0;
    logic [SW-1:0] fwd_sel_a, fwd_sel_b;
    logic          stall, flush, issue;
`ifdef HAZARD_STATS_EN
    logic [15:0]   stall_cnt, flush_cnt;
`endif

    hazard_fwd_unit #(.NSTAGES(NS), .REGW(RW), .LOAD_LAT(LL), .SELW(SW)) dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg),
        .id_is_load(id_is_load), .br_taken(br_taken), .mem_busy(mem_busy),
        .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .stall(stall), .flush(flush), .issue(issue)
`ifdef HAZARD_STATS_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rst, valid, use_rs, use_rt, wr_en, is_load, br, busy;
        bit [RW-1:0] rs, rt, wr_reg;
    } stim_t;
    typedef struct { int sel_a; int sel_b; bit stall; bit flush; bit issue; } exp_t;
    typedef struct { bit v; int r; bit ld; } ent_t;

    ent_t pipe[$];   // in-flight writes, index 0 = youngest
    exp_t exp_q[$];
    int errors = 0;
    int checks = 0;
    int m_stall_cnt = 0;
    int m_flush_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic int find(input int r);
        for (int k = 0; k < pipe.size(); k++)
            if (pipe[k].v && pipe[k].r == r && r != 0) return k;
        return -1;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        s.rst = 1'b1;
        return s;
    endfunction

    task automatic clear_model();
        foreach (pipe[k]) pipe[k].v = 1'b0;
        m_stall_cnt = 0;
        m_flush_cnt = 0;
    endtask

    // Drive one cycle's inputs and queue the response the reference expects.
    task automatic step(input stim_t s);
        exp_t e;
        ent_t ent;
        int   ma, mb;
        bit   haz;
        @(posedge clk); #1;
        reset_n = s.rst; id_valid = s.valid; id_rs = s.rs; id_rt = s.rt;
        id_use_rs = s.use_rs; id_use_rt = s.use_rt; id_wr_en = s.wr_en; id_wr_reg = s.wr_reg;
        id_is_load = s.is_load; br_taken = s.br; mem_busy = s.busy;
        e = '{default: 0};
        if (!s.rst) begin
            clear_model();
        end else begin
            ma = s.use_rs ? find(int'(s.rs)) : -1;
            mb = s.use_rt ? find(int'(s.rt)) : -1;
            e.sel_a = ma + 1;
            e.sel_b = mb + 1;
            haz = s.valid && ((ma >= 0 && pipe[ma].ld && ma < LL) || (mb >= 0 && pipe[mb].ld && mb < LL));
            if (s.busy) begin
                e.stall = 1'b1;
            end else begin
                if (s.br) begin
                    e.flush = 1'b1;
                    if (m_flush_cnt < 65535) m_flush_cnt++;
                end else if (haz) begin
                    e.stall = 1'b1;
                    if (m_stall_cnt < 65535) m_stall_cnt++;
                end else begin
                    e.issue = s.valid;
                end
                ent.v = e.issue && s.wr_en;
                ent.r = int'(s.wr_reg);
                ent.ld = s.is_load;
                pipe.push_front(ent);
                void'(pipe.pop_back());
            end
        end
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("mon_sel_a", fwd_sel_a, e.sel_a);
                chk("mon_sel_b", fwd_sel_b, e.sel_b);
                chk("mon_stall", stall, e.stall);
                chk("mon_flush", flush, e.flush);
                chk("mon_issue", issue, e.issue);
            end
        end
    end

    initial begin : driver
        stim_t s;
        for (int k = 0; k < NS; k++) pipe.push_back('{v: 1'b0, r: 0, ld: 1'b0});

        // Reset held with live-looking inputs: every output must stay 0.
        s = idle(); s.rst = 0; s.valid = 1; s.use_rs = 1; s.rs = 3; s.br = 1; s.busy = 1;
        step(s); #2;
        chk("rst_stall", stall, 0); chk("rst_flush", flush, 0); chk("rst_issue", issue, 0);
        chk("rst_sel_a", fwd_sel_a, 0);
        step(s);

        // ADDU r3 ; ADDU r4,r3,r3
        s = idle(); s.valid = 1; s.wr_en = 1; s.wr_reg = 3; step(s);
        s = idle(); s.valid = 1; s.use_rs = 1; s.use_rt = 1; s.rs = 3; s.rt = 3; s.wr_en = 1; s.wr_reg = 4;
        step(s); #2;
        chk("alu_sel_a", fwd_sel_a, 1); chk("alu_sel_b", fwd_sel_b, 1);
        chk("alu_stall", stall, 0); chk("alu_issue", issue, 1);

        // LW r5 ; ADDU r6,r5,r0 -> one stall cycle then forward from entry 1
        s = idle(); s.valid = 1; s.wr_en = 1; s.wr_reg = 5; s.is_load = 1; step(s);
        s = idle(); s.valid = 1; s.use_rs = 1; s.use_rt = 1; s.rs = 5; s.rt = 0; s.wr_en = 1; s.wr_reg = 6;
        step(s); #2;
        chk("lu_stall", stall, 1); chk("lu_issue0", issue, 0);
        step(s); #2;
        chk("lu_sel_a", fwd_sel_a, 2); chk("lu_issue1", issue, 1); chk("lu_sel_b", fwd_sel_b, 0);

        // LW r7 ; ADDU r7 ; read r7 -> youngest entry wins, no stall
        s = idle(); s.valid = 1; s.wr_en = 1; s.wr_reg = 7; s.is_load = 1; step(s);
        s = idle(); s.valid = 1; s.wr_en = 1; s.wr_reg = 7; step(s);
        s = idle(); s.valid = 1; s.use_rs = 1; s.rs = 7; step(s); #2;
        chk("young_sel", fwd_sel_a, 1); chk("young_stall", stall, 0);

        // write r0 ; read r0
        s = idle(); s.valid = 1; s.wr_en = 1; s.wr_reg = 0; step(s);
        s = idle(); s.valid = 1; s.use_rs = 1; s.rs = 0; step(s); #2;
        chk("r0_sel", fwd_sel_a, 0);

        // branch over a pending load-use hazard
        s = idle(); s.valid = 1; s.wr_en = 1; s.wr_reg = 8; s.is_load = 1; step(s);
        s = idle(); s.valid = 1; s.use_rs = 1; s.rs = 8; s.br = 1; step(s); #2;
        chk("br_flush", flush, 1); chk("br_stall", stall, 0); chk("br_issue", issue, 0);
        s.br = 0; step(s); #2;
        chk("br_after_sel", fwd_sel_a, 2); chk("br_after_flush", flush, 0);

        // three frozen cycles, one carrying a branch that must be ignored
        s = idle(); s.valid = 1; s.wr_en = 1; s.wr_reg = 9; step(s);
        s = idle(); s.valid = 1; s.use_rs = 1; s.rs = 9; s.busy = 1;
        for (int i = 0; i < 3; i++) begin
            s.br = (i == 1);
            step(s); #2;
            chk("frz_sel", fwd_sel_a, 1); chk("frz_stall", stall, 1); chk("frz_flush", flush, 0);
        end
        s.busy = 0; s.br = 0; step(s); #2;
        chk("frz_resume_sel", fwd_sel_a, 1); chk("frz_resume_issue", issue, 1);

        // asynchronous reset in the middle of a load-use stall
        s = idle(); s.valid = 1; s.wr_en = 1; s.wr_reg = 10; s.is_load = 1; step(s);
        s = idle(); s.valid = 1; s.use_rs = 1; s.rs = 10; step(s);
        @(negedge clk); #2;
        reset_n = 1'b0; #1;
        chk("mid_rst_stall", stall, 0); chk("mid_rst_issue", issue, 0); chk("mid_rst_sel", fwd_sel_a, 0);
`ifdef HAZARD_STATS_EN
        chk("mid_rst_scnt", stall_cnt, 0); chk("mid_rst_fcnt", flush_cnt, 0);
`endif
        clear_model();
        s.rst = 0; step(s); step(s);
        s.rst = 1; step(s); #2;
        chk("post_rst_sel", fwd_sel_a, 0); chk("post_rst_issue", issue, 1);

        // random traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            s = idle();
            s.valid = ($urandom_range(0, 99) < 85);
            if (s.valid) begin
                s.use_rs = $urandom_range(0, 1);
                s.use_rt = $urandom_range(0, 1);
                s.rs = RW'($urandom_range(0, 7));
                s.rt = RW'($urandom_range(0, 7));
                s.wr_en = ($urandom_range(0, 99) < 70);
                s.wr_reg = RW'($urandom_range(0, 7));
                s.is_load = ($urandom_range(0, 99) < 35);
            end
            s.br = ($urandom_range(0, 99) < 10);
            s.busy = ($urandom_range(0, 99) < 10);
            step(s);
        end
        step(idle());
        repeat (3) @(negedge clk);
        #1;
        chk("drain", exp_q.size(), 0);
`ifdef HAZARD_STATS_EN
        chk("stall_cnt", stall_cnt, m_stall_cnt);
        chk("flush_cnt", flush_cnt, m_flush_cnt);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
